// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end. Owns the fetch PC, issues in-order requests
//   to instruction memory and keeps requested/returned words in a small
//   in-order queue. The queue is a shift register, so slot 0 is always the
//   head and the decode-facing outputs come straight from slot-0 flops.
//   The head word is predecoded (imm16_d / ext_ctrl_d) when it is written.
//
//   Optional feature macro: FETCH_ADEL_EN
//     defined   : a misaligned redirect target produces one pre-filled slot
//                 with adel_d=1 / instr_d=0, and fetching halts until the
//                 next redirect.
//     undefined : redirect target is forced word aligned, adel_d is always 0.
//
// Ports
//   clk, reset                   clock (rising edge), async active-high reset
//   imem_req/addr/gnt            request channel to instruction memory
//   imem_rvalid/rdata            in-order response channel
//   redirect_valid/redirect_pc   kill everything in flight, restart at target
//   stall_d                      decode is not consuming the head this cycle
//   valid_d, instr_d, pc_d,      head instruction and its PC / link value
//   pc8_d
//   imm16_d, ext_ctrl_d          predecode for the immediate extender
//   adel_d                       fetch address error flag on the head
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [15:0] imm16_d,
  output logic [1:0]  ext_ctrl_d,
  output logic        adel_d
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int          ND = int'(DEPTH);

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_NONE = 2'b11;

  // Immediate-extension control from the opcode field.
  function automatic logic [1:0] ext_of(input logic [31:0] w);
    logic [1:0] e;
    e = EXT_SIGN;
    case (w[31:26])
      6'h0C, 6'h0D, 6'h0E: e = EXT_ZERO;
      6'h0F:               e = EXT_LUI;
      6'h00, 6'h02, 6'h03: e = EXT_NONE;
      default:             e = EXT_SIGN;
    endcase
    return e;
  endfunction

  // Fetch-side state.
  logic [31:0]   fpc_q, fpc_d;
  logic          req_q, req_d;
  logic [CW-1:0] alloc_q, alloc_d;   // slots holding a request or a word
  logic [CW-1:0] fill_q, fill_d;     // filled slots (always a prefix from head)
  logic [CW-1:0] drop_q, drop_d;     // killed responses still to be discarded
  logic          halt_q, halt_d;     // stopped after an address-error slot

  // Queue slots; index 0 is the head.
  logic          slot_full_q  [DEPTH];
  logic          slot_full_d  [DEPTH];
  logic [31:0]   slot_instr_q [DEPTH];
  logic [31:0]   slot_instr_d [DEPTH];
  logic [31:0]   slot_pc_q    [DEPTH];
  logic [31:0]   slot_pc_d    [DEPTH];
  logic [31:0]   slot_pc8_q   [DEPTH];
  logic [31:0]   slot_pc8_d   [DEPTH];
  logic [1:0]    slot_ext_q   [DEPTH];
  logic [1:0]    slot_ext_d   [DEPTH];
  logic          slot_adel_q  [DEPTH];
  logic          slot_adel_d  [DEPTH];

  logic          gnt_c;
  logic          pop_c;
  logic          redir_adel_c;
  logic [31:0]   redir_target_c;
  logic [CW:0]   outstanding_c;

  assign gnt_c = req_q & imem_gnt;
  assign pop_c = slot_full_q[0] & ~stall_d;

`ifdef FETCH_ADEL_EN
  assign redir_adel_c   = (redirect_pc[1:0] != 2'b00);
  assign redir_target_c = redirect_pc;
`else
  assign redir_adel_c   = 1'b0;
  assign redir_target_c = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Next-state: redirect, response fill/drop, grant push, head pop.
  always_comb begin
    fpc_d         = fpc_q;
    req_d         = req_q;
    alloc_d       = alloc_q;
    fill_d        = fill_q;
    drop_d        = drop_q;
    halt_d        = halt_q;
    outstanding_c = '0;
    for (int i = 0; i < ND; i++) begin
      slot_full_d[i]  = slot_full_q[i];
      slot_instr_d[i] = slot_instr_q[i];
      slot_pc_d[i]    = slot_pc_q[i];
      slot_pc8_d[i]   = slot_pc8_q[i];
      slot_ext_d[i]   = slot_ext_q[i];
      slot_adel_d[i]  = slot_adel_q[i];
    end

    if (redirect_valid) begin
      for (int i = 0; i < ND; i++) begin
        slot_full_d[i]  = 1'b0;
        slot_instr_d[i] = '0;
        slot_pc_d[i]    = '0;
        slot_pc8_d[i]   = '0;
        slot_ext_d[i]   = EXT_NONE;
        slot_adel_d[i]  = 1'b0;
      end
      alloc_d = '0;
      fill_d  = '0;
      halt_d  = 1'b0;
      fpc_d   = redir_target_c;
      // Everything still owed by memory after this edge must be discarded:
      // old drops + unfilled requests + a grant now, minus a response now.
      outstanding_c = (CW+1)'(drop_q) + (CW+1)'(alloc_q - fill_q) + (CW+1)'(gnt_c);
      if (imem_rvalid && (outstanding_c != '0)) begin
        outstanding_c = outstanding_c - (CW+1)'(1);
      end
      drop_d = CW'(outstanding_c);
      if (redir_adel_c) begin
        slot_full_d[0]  = 1'b1;
        slot_instr_d[0] = '0;
        slot_pc_d[0]    = redirect_pc;
        slot_pc8_d[0]   = redirect_pc + 32'd8;
        slot_ext_d[0]   = EXT_NONE;
        slot_adel_d[0]  = 1'b1;
        alloc_d         = CW'(1);
        fill_d          = CW'(1);
        halt_d          = 1'b1;
      end
    end else begin
      // Response: discard if owed to a killed fetch, else fill oldest unfilled.
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (fill_q < alloc_q) begin
          for (int i = 0; i < ND; i++) begin
            if (CW'(i) == fill_q) begin
              slot_full_d[i]  = 1'b1;
              slot_instr_d[i] = imem_rdata;
              slot_ext_d[i]   = ext_of(imem_rdata);
            end
          end
          fill_d = fill_q + CW'(1);
        end
      end
      // Grant: allocate the tail slot tagged with the fetch PC.
      if (gnt_c) begin
        for (int i = 0; i < ND; i++) begin
          if (CW'(i) == alloc_q) begin
            slot_pc_d[i]  = fpc_q;
            slot_pc8_d[i] = fpc_q + 32'd8;
          end
        end
        alloc_d = alloc_d + CW'(1);
        fpc_d   = fpc_q + 32'd4;
      end
      // Pop: shift the queue toward the head.
      if (pop_c) begin
        for (int i = 0; i < ND - 1; i++) begin
          slot_full_d[i]  = slot_full_d[i+1];
          slot_instr_d[i] = slot_instr_d[i+1];
          slot_pc_d[i]    = slot_pc_d[i+1];
          slot_pc8_d[i]   = slot_pc8_d[i+1];
          slot_ext_d[i]   = slot_ext_d[i+1];
          slot_adel_d[i]  = slot_adel_d[i+1];
        end
        slot_full_d[ND-1]  = 1'b0;
        slot_instr_d[ND-1] = '0;
        slot_pc_d[ND-1]    = '0;
        slot_pc8_d[ND-1]   = '0;
        slot_ext_d[ND-1]   = EXT_NONE;
        slot_adel_d[ND-1]  = 1'b0;
        alloc_d = alloc_d - CW'(1);
        fill_d  = fill_d - CW'(1);
      end
    end

    // Request next cycle while allocated + owed responses leave room.
    req_d = ~halt_d & (((CW+1)'(alloc_d) + (CW+1)'(drop_d)) < (CW+1)'(DEPTH));
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      req_q   <= 1'b0;
      alloc_q <= '0;
      fill_q  <= '0;
      drop_q  <= '0;
      halt_q  <= 1'b0;
      for (int i = 0; i < ND; i++) begin
        slot_full_q[i]  <= 1'b0;
        slot_instr_q[i] <= '0;
        slot_pc_q[i]    <= '0;
        slot_pc8_q[i]   <= '0;
        slot_ext_q[i]   <= EXT_NONE;
        slot_adel_q[i]  <= 1'b0;
      end
    end else begin
      fpc_q   <= fpc_d;
      req_q   <= req_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      drop_q  <= drop_d;
      halt_q  <= halt_d;
      for (int i = 0; i < ND; i++) begin
        slot_full_q[i]  <= slot_full_d[i];
        slot_instr_q[i] <= slot_instr_d[i];
        slot_pc_q[i]    <= slot_pc_d[i];
        slot_pc8_q[i]   <= slot_pc8_d[i];
        slot_ext_q[i]   <= slot_ext_d[i];
        slot_adel_q[i]  <= slot_adel_d[i];
      end
    end
  end

  // Outputs come directly from the request flop, fetch PC and head slot.
  assign imem_req   = req_q;
  assign imem_addr  = fpc_q;
  assign valid_d    = slot_full_q[0];
  assign instr_d    = slot_instr_q[0];
  assign pc_d       = slot_pc_q[0];
  assign pc8_d      = slot_pc8_q[0];
  assign imm16_d    = slot_instr_q[0][15:0];
  assign ext_ctrl_d = slot_ext_q[0];
  assign adel_d     = slot_adel_q[0];

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Randomized bench for fetch_stage. A memory responder grants requests and
//   returns words in order after a random latency. The reference model is the
//   architectural instruction stream: after reset or a redirect the decode
//   side must see target, target+4, ... with the memory word at each address.
//   The stimulus process pushes that stream into a queue; a monitor pops and
//   compares on every head consumption.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic [15:0] imm16_d;
  logic [1:0]  ext_ctrl_d;
  logic        adel_d;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .pc8_d(pc8_d), .imm16_d(imm16_d), .ext_ctrl_d(ext_ctrl_d), .adel_d(adel_d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pops   = 0;
  int          cyc      = 0;
  int          gnt_pct, max_lat, stall_pct, redir_permil;
  logic [31:0] exp_next;
  logic        halted;
  logic        force_redir;
  logic [31:0] force_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory image: a few fixed words at the reset vector, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0]  ops [8];
    logic [31:0] h;
    case (a)
      32'h0000_3000: return 32'h3402_1234;
      32'h0000_3004: return 32'h3C01_8000;
      32'h0000_3008: return 32'h2001_FFFF;
      32'h0000_300C: return 32'h0000_0020;
      default: ;
    endcase
    ops = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h02, 6'h03, 6'h08};
    h   = a * 32'h9E37_79B1;
    return {ops[h[31:29]], h[25:0] ^ a[27:2]};
  endfunction

  function automatic logic [1:0] exp_ext(input logic [31:0] w);
    case (w[31:26])
      6'h0C, 6'h0D, 6'h0E: return 2'b01;
      6'h0F:               return 2'b10;
      6'h00, 6'h02, 6'h03: return 2'b11;
      default:             return 2'b00;
    endcase
  endfunction

  // Reference model: a redirect restarts the expected stream.
  function automatic void model_redirect(input logic [31:0] target);
    exp_t e;
    exp_q.delete();
`ifdef FETCH_ADEL_EN
    if (target[1:0] != 2'b00) begin
      e.pc = target; e.instr = '0; e.adel = 1'b1;
      exp_q.push_back(e);
      halted = 1'b1;
      return;
    end
`endif
    exp_next = {target[31:2], 2'b00};
    halted   = 1'b0;
  endfunction

  function automatic void refill();
    exp_t e;
    while (!halted && exp_q.size() < 6) begin
      e.pc = exp_next; e.instr = mem_word(exp_next); e.adel = 1'b0;
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
  endfunction

  // One cycle of stimulus: memory response, grant, stall and redirect.
  task automatic step();
    rsp_t r;
    @(negedge clk);
    cyc++;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(r.addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + int'($urandom_range(max_lat, 1));
      rsp_q.push_back(r);
      check("outstanding_bound", 64'(rsp_q.size() <= DEPTH), 64'd1);
    end
    stall_d = ($urandom_range(99) < stall_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if ($urandom_range(999) < redir_permil) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000 + ($urandom_range(1023) << 2);
      if ($urandom_range(9) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
    if (redirect_valid) model_redirect(redirect_pc);
    refill();
  endtask

  // Monitor: compare every consumed head against the expected stream.
  initial begin : monitor
    exp_t        e;
    logic        hold;
    logic [31:0] h_instr, h_pc;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("stall_hold_valid", 64'(valid_d), 64'd1);
        check("stall_hold_instr", 64'(instr_d), 64'(h_instr));
        check("stall_hold_pc", 64'(pc_d), 64'(h_pc));
      end
      hold = 1'b0;
      if (!valid_d) begin
        check("idle_instr_zero", 64'(instr_d), 64'd0);
      end else if (!redirect_valid) begin
        if (stall_d) begin
          hold = 1'b1; h_instr = instr_d; h_pc = pc_d;
        end else if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got pc_d %h instr_d %h expected no instruction", pc_d, instr_d);
        end else begin
          e = exp_q.pop_front();
          n_pops++;
          check("pc_d", 64'(pc_d), 64'(e.pc));
          check("instr_d", 64'(instr_d), 64'(e.instr));
          check("predecode", {imm16_d, ext_ctrl_d, pc8_d, adel_d},
                {e.instr[15:0], exp_ext(e.instr), e.pc + 32'd8, e.adel});
        end
      end
    end
  end

  initial begin : watchdog
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, t1;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall_d = 1'b0;
    force_redir = 1'b0; force_pc = '0; halted = 1'b0; exp_next = RESET_PC;
    gnt_pct = 100; max_lat = 1; stall_pct = 0; redir_permil = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
    check("rst_valid_d", 64'(valid_d), 64'd0);
    check("rst_instr_d", 64'(instr_d), 64'd0);
    check("rst_pc_d", 64'(pc_d), 64'd0);
    check("rst_imm16_d", 64'(imm16_d), 64'd0);
    check("rst_ext_ctrl_d", 64'(ext_ctrl_d), 64'd3);
    check("rst_adel_d", 64'(adel_d), 64'd0);
    model_redirect(RESET_PC);
    refill();
    reset = 1'b0;

    // Full-rate memory: grant->valid_d latency with one-cycle responses.
    t0 = -1; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (t0 < 0 && imem_req && imem_gnt) t0 = cyc;
      if (t1 < 0 && valid_d) t1 = cyc;
    end
    check("first_gnt_cycle", 64'(t0), 64'd1);
    check("gnt_to_valid_latency", 64'(t1 - t0), 64'd2);
    repeat (10) step();

    // Decode stalled with a full queue: requests stop, head held.
    stall_pct = 100; max_lat = 3;
    repeat (15) step();
    check("full_stall_req", 64'(imem_req), 64'd0);
    check("full_stall_valid", 64'(valid_d), 64'd1);
    stall_pct = 0;
    repeat (15) step();

    // Redirect with fetches in flight.
    gnt_pct = 100; max_lat = 3;
    force_redir = 1'b1; force_pc = 32'h0000_3400;
    repeat (25) step();

    // Misaligned redirect target.
    force_redir = 1'b1; force_pc = 32'h0000_3402;
    repeat (20) step();
`ifdef FETCH_ADEL_EN
    check("adel_halt_req", 64'(imem_req), 64'd0);
`endif
    force_redir = 1'b1; force_pc = 32'h0000_3000;
    repeat (20) step();

    // Randomized traffic.
    gnt_pct = 60; max_lat = 4; stall_pct = 30; redir_permil = 25;
    repeat (3000) step();

    // Drain.
    gnt_pct = 100; stall_pct = 0; redir_permil = 0;
    force_redir = 1'b1; force_pc = 32'h0000_3100;
    repeat (40) step();
    check("progress_pops", 64'(n_pops > 200), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
